// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte/half/word data memory with wait states, alignment and range checks
module data_mem_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int MEM_BYTES   = 256,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [WORD_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  busy
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int LW = WORD_WIDTH + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic                    signed_q;
  logic [1:0]              size_q;
  logic [WORD_WIDTH-1:0]   addr_q;
  logic [WORD_WIDTH-1:0]   wdata_q;
  logic [7:0]              mem_q [MEM_BYTES];
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [WORD_WIDTH-1:0]   rdata_q;

  logic [WORD_WIDTH-1:0]   offset;
  logic [LW-1:0]           last_byte;
  logic [2:0]              nbytes;
  logic                    err;
  logic [AW-1:0]           idx0, idx1, idx2, idx3;
  logic [7:0]              b0, b1, b2, b3;
  logic [WORD_WIDTH-1:0]   load_data;

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == BUSY);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign rdata      = rdata_q;

  // Offset wraps modulo 2^WORD_WIDTH, so addresses below the base land far out of range
  assign offset = addr_q - WORD_WIDTH'(BASE_ADDR);
  assign idx0   = offset[AW-1:0];
  assign idx1   = idx0 + AW'(1);
  assign idx2   = idx0 + AW'(2);
  assign idx3   = idx0 + AW'(3);
  assign b0     = mem_q[idx0];
  assign b1     = mem_q[idx1];
  assign b2     = mem_q[idx2];
  assign b3     = mem_q[idx3];

  always_comb begin
    nbytes = 3'd0;
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      2'b10:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    // One extra bit keeps offset + bytes - 1 from wrapping back into range
    last_byte = {1'b0, offset} + LW'(nbytes) - LW'(1);
    err = (size_q == 2'b11)
       || ((size_q == 2'b01) && offset[0])
       || ((size_q == 2'b10) && (offset[1:0] != 2'b00))
       || (last_byte >= LW'(MEM_BYTES));
  end

  always_comb begin
    load_data = '0;
    case (size_q)
      2'b00:   load_data = {{(WORD_WIDTH-8){signed_q & b0[7]}}, b0};
      2'b01:   load_data = {{(WORD_WIDTH-16){signed_q & b1[7]}}, b1, b0};
      default: load_data = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'(i);
      end
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= addr;
            wdata_q  <= wdata;
            cnt_q    <= 4'(WAIT_STATES);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err;
            rdata_q      <= (we_q || err) ? '0 : load_data;
            if (we_q && !err) begin
              mem_q[idx0] <= wdata_q[7:0];
              if (size_q != 2'b00) begin
                mem_q[idx1] <= wdata_q[15:8];
              end
              if (size_q == 2'b10) begin
                mem_q[idx2] <= wdata_q[23:16];
                mem_q[idx3] <= wdata_q[31:24];
              end
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
